// File: rtl/serial_addsub_if.sv
// Operand/result bundle between the trisc controller (master) and the bit-serial ALU (slave).
// start/sub/a/b are sampled on accept; busy/done/sum/cout/ovf come back registered.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (output start, sub, a, b, input busy, done, sum, cout, ovf);
  modport slave  (input start, sub, a, b, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial add/sub: one full adder reused LSB-first over WIDTH cycles, done pulses WIDTH+1 cycles after start.
// No backpressure: start is only sampled in IDLE, results hold until the next accepted start.
module fulladder (
  input  logic ai,
  input  logic bi,
  input  logic cini,
  output logic si,
  output logic couti
);
  assign si    = ai ^ bi ^ cini;
  assign couti = (ai & bi) | (cini & (ai ^ bi));
endmodule

module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_addsub_if.slave       bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;
  logic             si;
  logic             couti;

  fulladder u_fa (
    .ai    (a_sh_q[0]),
    .bi    (b_sh_q[0]),
    .cini  (carry_q),
    .si    (si),
    .couti (couti)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            // Subtract as a + ~b + 1: invert B and seed the carry with sub.
            a_sh_q  <= bus.a;
            b_sh_q  <= bus.b ^ {WIDTH{bus.sub}};
            carry_q <= bus.sub;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          sum_q   <= {si, sum_q[WIDTH-1:1]};
          carry_q <= couti;
          if (cnt_q == LAST) begin
            // carry_q here is the carry into the MSB.
            cout_q  <= couti;
            ovf_q   <= couti ^ carry_q;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: an 8-bit and a 2-bit instance checked every cycle against an op-level
// arithmetic model, plus directed vectors with hand-computed results, latency and pulse counts.
module tb_serial_addsub;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       st[2];
  logic       sb[2];
  logic [7:0] av[2];
  logic [7:0] bv[2];
  logic       busy_o[2];
  logic       done_o[2];
  logic [7:0] sum_o[2];
  logic       cout_o[2];
  logic       ovf_o[2];

  serial_addsub_if #(.WIDTH(8)) if8 ();
  serial_addsub_if #(.WIDTH(2)) if2 ();

  serial_addsub #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
  serial_addsub #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  assign if8.start = st[0];
  assign if8.sub   = sb[0];
  assign if8.a     = av[0];
  assign if8.b     = bv[0];
  assign if2.start = st[1];
  assign if2.sub   = sb[1];
  assign if2.a     = av[1][1:0];
  assign if2.b     = bv[1][1:0];
  assign busy_o[0] = if8.busy;
  assign done_o[0] = if8.done;
  assign sum_o[0]  = if8.sum;
  assign cout_o[0] = if8.cout;
  assign ovf_o[0]  = if8.ovf;
  assign busy_o[1] = if2.busy;
  assign done_o[1] = if2.done;
  assign sum_o[1]  = {6'b0, if2.sum};
  assign cout_o[1] = if2.cout;
  assign ovf_o[1]  = if2.ovf;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Plain-arithmetic reference for one w-bit add or subtract.
  function automatic void calc(input int w, input logic [7:0] a, input logic [7:0] b, input logic s,
                               output logic [7:0] r, output logic co, output logic ov);
    longint m, lim, ua, ub, sa, sbv, res, sr;
    m   = (longint'(1) << w) - 1;
    lim = longint'(1) << (w - 1);
    ua  = longint'(a) & m;
    ub  = longint'(b) & m;
    sa  = (ua >= lim) ? ua - 2 * lim : ua;
    sbv = (ub >= lim) ? ub - 2 * lim : ub;
    if (s) begin
      res = ua - ub;
      co  = (ua >= ub);
      sr  = sa - sbv;
    end else begin
      res = ua + ub;
      co  = (res > m);
      sr  = sa + sbv;
    end
    r  = 8'(res & m);
    ov = (sr >= lim) || (sr < -lim);
  endfunction

  // Op-level model: an accepted op occupies WIDTH busy cycles, then one done cycle, then idle.
  int         m_left[2] = '{0, 0};
  bit         m_done[2] = '{0, 0};
  logic [7:0] m_sum[2]  = '{8'h0, 8'h0};
  logic       m_cout[2] = '{1'b0, 1'b0};
  logic       m_ovf[2]  = '{1'b0, 1'b0};
  logic [7:0] p_sum[2];
  logic       p_cout[2];
  logic       p_ovf[2];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_left[k] = 0;
        m_done[k] = 0;
        m_sum[k]  = 8'h0;
        m_cout[k] = 1'b0;
        m_ovf[k]  = 1'b0;
      end else if (m_done[k]) begin
        m_done[k] = 0;
      end else if (m_left[k] > 0) begin
        m_left[k]--;
        if (m_left[k] == 0) begin
          m_done[k] = 1;
          m_sum[k]  = p_sum[k];
          m_cout[k] = p_cout[k];
          m_ovf[k]  = p_ovf[k];
        end
      end else if (st[k]) begin
        calc((k == 0) ? 8 : 2, av[k], bv[k], sb[k], p_sum[k], p_cout[k], p_ovf[k]);
        m_left[k] = (k == 0) ? 8 : 2;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("busy%0d", k), 32'(busy_o[k]), 32'(m_left[k] > 0));
      chk($sformatf("done%0d", k), 32'(done_o[k]), 32'(m_done[k]));
      if (m_left[k] == 0) begin
        chk($sformatf("sum%0d", k), 32'(sum_o[k]), 32'(m_sum[k]));
        chk($sformatf("cout%0d", k), 32'(cout_o[k]), 32'(m_cout[k]));
        chk($sformatf("ovf%0d", k), 32'(ovf_o[k]), 32'(m_ovf[k]));
      end
    end
  end

  task automatic wait_done(input int k, input string nm);
    int n = 0;
    while (!done_o[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_done_seen"}, 32'(done_o[k]), 32'd1);
  endtask

  task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [7:0] es, input logic ec, input logic eo, input string nm);
    int t0;
    @(negedge clk);
    av[k] = a; bv[k] = b; sb[k] = s; st[k] = 1'b1;
    t0 = cyc;
    @(negedge clk);
    st[k] = 1'b0;
    wait_done(k, nm);
    chk({nm, "_latency"}, 32'(cyc - t0), 32'((k == 0) ? 9 : 3));
    chk({nm, "_sum"}, 32'(sum_o[k]), 32'(es));
    chk({nm, "_cout"}, 32'(cout_o[k]), 32'(ec));
    chk({nm, "_ovf"}, 32'(ovf_o[k]), 32'(eo));
  endtask

  initial begin
    logic [7:0] r;
    logic       c, o;
    int         pulses, last_done;

    for (int k = 0; k < 2; k++) begin
      st[k] = 1'b0; sb[k] = 1'b0; av[k] = 8'h0; bv[k] = 8'h0;
    end

    // Pin the model itself with hand-computed results.
    calc(8, 8'h5A, 8'h3C, 1'b0, r, c, o);
    chk("model_add", {23'b0, r, c, o}, {23'b0, 8'h96, 1'b0, 1'b1});
    calc(8, 8'h80, 8'h01, 1'b1, r, c, o);
    chk("model_sub", {23'b0, r, c, o}, {23'b0, 8'h7F, 1'b1, 1'b1});
    calc(2, 8'h03, 8'h01, 1'b0, r, c, o);
    chk("model_w2", {23'b0, r, c, o}, {23'b0, 8'h00, 1'b1, 1'b0});

    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_o[0]), 32'd0);
    chk("rst_done", 32'(done_o[0]), 32'd0);
    chk("rst_res", {23'b0, sum_o[0], cout_o[0], ovf_o[0]}, 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle_busy", 32'(busy_o[0]), 32'd0);

    run_op(0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, "add5a3c");
    run_op(0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "addff01");
    run_op(0, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub8001");
    run_op(0, 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, "sub1020");

    // Toggle start and scramble operands while shifting.
    @(negedge clk);
    av[0] = 8'h10; bv[0] = 8'h20; sb[0] = 1'b1; st[0] = 1'b1;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i < 6) begin
        st[0] = ~st[0];
        av[0] = 8'($urandom);
        bv[0] = 8'($urandom);
        sb[0] = 1'($urandom);
      end else begin
        st[0] = 1'b0;
      end
      if (done_o[0]) begin
        pulses++;
        chk("toggle_sum", 32'(sum_o[0]), 32'h0F0);
      end
    end
    chk("toggle_pulses", 32'(pulses), 32'd1);

    // Asynchronous reset in the middle of a shift.
    @(negedge clk);
    av[0] = 8'h5A; bv[0] = 8'h3C; sb[0] = 1'b0; st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_abort_busy", 32'(busy_o[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy_o[0]), 32'd0);
    chk("abort_res", {23'b0, sum_o[0], cout_o[0], ovf_o[0]}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, "after_abort");

    // start held high: back-to-back ops every WIDTH+2 cycles.
    @(negedge clk);
    av[0] = 8'h01; bv[0] = 8'h01; sb[0] = 1'b0; st[0] = 1'b1;
    pulses = 0;
    last_done = -1;
    for (int i = 0; i < 44; i++) begin
      @(negedge clk);
      if (i == 29) st[0] = 1'b0;
      if (done_o[0]) begin
        pulses++;
        chk("held_sum", 32'(sum_o[0]), 32'h02);
        if (last_done >= 0) chk("held_period", 32'(cyc - last_done), 32'd10);
        last_done = cyc;
      end
    end
    chk("held_pulses", 32'(pulses), 32'd3);

    run_op(1, 8'h03, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "w2_add31");
    run_op(1, 8'h01, 8'h02, 1'b1, 8'h03, 1'b0, 1'b1, "w2_sub12");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
